// File: rtl/saa1099_pkg.sv
// saa1099_pkg: shared types and constants for the saa1099 write scheduler.
//   state_t      - scheduler FSM states
//   seq_entry_t  - one sequencer request: register index + data byte
//   ENV_ADDR0/1  - envelope control registers; re-latching these on the chip
//                  produces a spurious envelope external clock
package saa1099_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CPU_BEAT,
    SEQ_ADDR,
    SEQ_DATA,
    RESTORE
  } state_t;

  typedef struct packed {
    logic [4:0] reg_idx;
    logic [7:0] data;
  } seq_entry_t;

  localparam logic [4:0] ENV_ADDR0 = 5'h18;
  localparam logic [4:0] ENV_ADDR1 = 5'h19;

  // A sequencer transaction ends by restoring the CPU's address, so it must
  // not start while that address is an envelope register.
  function automatic logic is_env_addr(input logic [4:0] a);
    return (a == ENV_ADDR0) || (a == ENV_ADDR1);
  endfunction

endpackage

// File: rtl/saa1099_seq_fifo.sv
// saa1099_seq_fifo: synchronous FIFO of seq_entry_t.
//   clk_sys, rst_n     - clock, synchronous active-low reset
//   push, push_data    - write an entry (ignored when full)
//   pop                - drop the head entry (ignored when empty)
//   head               - current head entry (valid when !empty)
//   empty, full        - occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module saa1099_seq_fifo
  import saa1099_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       push,
  input  seq_entry_t push_data,
  input  logic       pop,
  output seq_entry_t head,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  seq_entry_t  mem [DEPTH];
  logic [AW:0] wp, rp;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign head  = mem[rp[AW-1:0]];

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wp[AW-1:0]] <= push_data;
        wp              <= wp + PTR_ONE;
      end
      if (pop && !empty) rp <= rp + PTR_ONE;
    end
  end

endmodule

// File: rtl/saa1099_wr_sched.sv
// saa1099_wr_sched: shares the saa1099 bus port between CPU I/O writes
// (one-entry buffer, high priority) and a sequencer FIFO of register/data
// pairs. Every write becomes WR_LOW cycles of cs_n=wr_n=0 followed by
// WR_GAP cycles high; a0/din are held from the first low cycle through the gap.
//   clk_sys, rst_n          - clock, synchronous active-low reset
//   cpu_wr/cpu_a0/cpu_din   - CPU write strobe, address/data select, value
//   cpu_ovf                 - sticky: a CPU strobe was dropped
//   seq_valid/seq_ready     - sequencer handshake; seq_reg/seq_data payload
//   saa_cs_n/a0/wr_n/din    - chip bus
//   shadow_addr             - last address the CPU wrote
//   busy                    - engine active or anything queued
// A sequencer transaction (address, data, restore of the CPU address) is
// atomic so the chip's address latch always ends equal to shadow_addr.
module saa1099_wr_sched
  import saa1099_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WR_LOW     = 2,
  parameter int WR_GAP     = 2
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       cpu_wr,
  input  logic       cpu_a0,
  input  logic [7:0] cpu_din,
  output logic       cpu_ovf,
  input  logic       seq_valid,
  output logic       seq_ready,
  input  logic [4:0] seq_reg,
  input  logic [7:0] seq_data,
  output logic       saa_cs_n,
  output logic       saa_a0,
  output logic       saa_wr_n,
  output logic [7:0] saa_din,
  output logic [4:0] shadow_addr,
  output logic       busy
);

  localparam int CNT_MAX = (WR_LOW > WR_GAP) ? WR_LOW : WR_GAP;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] LOW_LAST = CW'(WR_LOW - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(WR_GAP - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t          state;
  logic            in_low;
  logic [CW-1:0]   cnt;
  logic            cpu_full, cpu_a0_q;
  logic [7:0]      cpu_din_q;
  logic [7:0]      cur_data;
  logic            addr_changed;

  seq_entry_t      fifo_head;
  logic            fifo_empty, fifo_full, fifo_pop;

  logic            beat_end, launch, launch_a0;
  state_t          launch_state;
  logic [7:0]      launch_din;

  assign seq_ready = !fifo_full;
  assign busy      = (state != IDLE) || cpu_full || !fifo_empty;

  saa1099_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .push      (seq_valid && !fifo_full),
    .push_data ('{reg_idx: seq_reg, data: seq_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Decide whether a new beat starts on the next cycle. Beats inside a
  // sequencer transaction launch on the last gap cycle of the previous beat,
  // so the gap stays exactly WR_GAP cycles.
  always_comb begin
    beat_end     = (state != IDLE) && !in_low && (cnt == GAP_LAST);
    launch       = 1'b0;
    launch_state = IDLE;
    launch_a0    = 1'b0;
    launch_din   = '0;
    fifo_pop     = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_full) begin
          launch       = 1'b1;
          launch_state = CPU_BEAT;
          launch_a0    = cpu_a0_q;
          launch_din   = cpu_din_q;
        end else if (!fifo_empty && !is_env_addr(shadow_addr)) begin
          fifo_pop = 1'b1;
          launch   = 1'b1;
          if (fifo_head.reg_idx == shadow_addr) begin
            // chip latch already points there: go straight to the data beat
            launch_state = SEQ_DATA;
            launch_a0    = 1'b0;
            launch_din   = fifo_head.data;
          end else begin
            launch_state = SEQ_ADDR;
            launch_a0    = 1'b1;
            launch_din   = {3'b000, fifo_head.reg_idx};
          end
        end
      end
      SEQ_ADDR: begin
        if (beat_end) begin
          launch       = 1'b1;
          launch_state = SEQ_DATA;
          launch_a0    = 1'b0;
          launch_din   = cur_data;
        end
      end
      SEQ_DATA: begin
        if (beat_end && addr_changed) begin
          launch       = 1'b1;
          launch_state = RESTORE;
          launch_a0    = 1'b1;
          launch_din   = {3'b000, shadow_addr};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_low       <= 1'b0;
      cnt          <= '0;
      cpu_full     <= 1'b0;
      cpu_a0_q     <= 1'b0;
      cpu_din_q    <= '0;
      cpu_ovf      <= 1'b0;
      cur_data     <= '0;
      addr_changed <= 1'b0;
      shadow_addr  <= '0;
      saa_cs_n     <= 1'b1;
      saa_wr_n     <= 1'b1;
      saa_a0       <= 1'b0;
      saa_din      <= '0;
    end else begin
      if (cpu_wr) begin
        if (!cpu_full) begin
          cpu_full  <= 1'b1;
          cpu_a0_q  <= cpu_a0;
          cpu_din_q <= cpu_din;
        end else begin
          cpu_ovf <= 1'b1;
        end
      end
      if (beat_end && state == CPU_BEAT) cpu_full <= 1'b0;

      if (fifo_pop) begin
        cur_data     <= fifo_head.data;
        addr_changed <= (fifo_head.reg_idx != shadow_addr);
      end

      if (launch) begin
        state    <= launch_state;
        saa_cs_n <= 1'b0;
        saa_wr_n <= 1'b0;
        saa_a0   <= launch_a0;
        saa_din  <= launch_din;
        in_low   <= 1'b1;
        cnt      <= '0;
        if (launch_state == CPU_BEAT && launch_a0) shadow_addr <= launch_din[4:0];
      end else if (beat_end) begin
        state <= IDLE;
      end else if (state != IDLE) begin
        if (in_low && cnt == LOW_LAST) begin
          saa_cs_n <= 1'b1;
          saa_wr_n <= 1'b1;
          in_low   <= 1'b0;
          cnt      <= '0;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_saa1099_wr_sched.sv
// Directed bench for saa1099_wr_sched: a bus monitor records every beat
// {a0,din}, checks low width and gap, and models the chip's address latch.
module tb_saa1099_wr_sched;

  localparam int WR_LOW = 2;
  localparam int WR_GAP = 2;

  logic       clk_sys = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_wr = 1'b0, cpu_a0 = 1'b0;
  logic [7:0] cpu_din = '0;
  logic       cpu_ovf;
  logic       seq_valid = 1'b0, seq_ready;
  logic [4:0] seq_reg = '0;
  logic [7:0] seq_data = '0;
  logic       saa_cs_n, saa_a0, saa_wr_n;
  logic [7:0] saa_din;
  logic [4:0] shadow_addr;
  logic       busy;

  saa1099_wr_sched #(.FIFO_DEPTH(4), .WR_LOW(WR_LOW), .WR_GAP(WR_GAP)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .cpu_wr(cpu_wr), .cpu_a0(cpu_a0), .cpu_din(cpu_din), .cpu_ovf(cpu_ovf),
    .seq_valid(seq_valid), .seq_ready(seq_ready), .seq_reg(seq_reg), .seq_data(seq_data),
    .saa_cs_n(saa_cs_n), .saa_a0(saa_a0), .saa_wr_n(saa_wr_n), .saa_din(saa_din),
    .shadow_addr(shadow_addr), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- bus monitor / chip model ----------------
  logic [8:0] beats[$];
  logic [8:0] cur_beat;
  logic [4:0] latch = '0;
  bit         in_beat = 0, have_prev = 0;
  int         lo_len = 0, hi_len = 0;

  always @(posedge clk_sys) begin
    #1;
    if (!rst_n) begin
      in_beat = 0; have_prev = 0; hi_len = 0; latch = '0;
      beats.delete();
    end else begin
      chk("cs_n_tracks_wr_n", saa_cs_n, saa_wr_n);
      if (!saa_wr_n) begin
        if (!in_beat) begin
          in_beat  = 1;
          lo_len   = 1;
          cur_beat = {saa_a0, saa_din};
          if (have_prev) begin
            checks++;
            if (hi_len < WR_GAP) begin
              errors++;
              $display("FAIL gap_len: got %0d expected at least %0d", hi_len, WR_GAP);
            end
          end
        end else begin
          lo_len++;
          chk("a0_din_stable", {saa_a0, saa_din}, cur_beat);
        end
      end else if (in_beat) begin
        in_beat = 0;
        chk("low_len", lo_len, WR_LOW);
        beats.push_back(cur_beat);
        if (cur_beat[8]) latch = cur_beat[4:0];
        have_prev = 1;
        hi_len    = 1;
      end else begin
        hi_len++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cpu_write(input logic a0, input logic [7:0] d);
    @(negedge clk_sys);
    cpu_wr = 1'b1; cpu_a0 = a0; cpu_din = d;
    @(negedge clk_sys);
    cpu_wr = 1'b0;
  endtask

  task automatic seq_push(input logic [4:0] r, input logic [7:0] d);
    @(negedge clk_sys);
    seq_valid = 1'b1; seq_reg = r; seq_data = d;
    @(negedge clk_sys);
    seq_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    chk({name, "_idle_timeout"}, busy, 1'b0);
  endtask

  task automatic wait_low(input string name);
    int n = 0;
    while (saa_wr_n && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    chk({name, "_wr_low_timeout"}, saa_wr_n, 1'b0);
  endtask

  task automatic check_beats(input string name, input int n,
                             input logic [8:0] e0, input logic [8:0] e1,
                             input logic [8:0] e2, input logic [8:0] e3);
    logic [8:0] e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk($sformatf("%s_beat_count", name), beats.size(), n);
    for (int i = 0; i < n && i < beats.size(); i++)
      chk($sformatf("%s_beat%0d", name, i), beats[i], e[i]);
    beats.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         is_seq;
    logic       a0;
    logic [7:0] d;      // cpu_din or seq_data
    logic [4:0] r;      // seq_reg
    int         n;
    logic [8:0] e0, e1, e2;
    logic [4:0] shadow;
  } vec_t;

  vec_t vecs[6];
  int   accepted;

  initial begin
    vecs[0] = '{0, 1'b1, 8'h08, 5'h00, 1, 9'h108, 9'h000, 9'h000, 5'h08};
    vecs[1] = '{0, 1'b0, 8'h40, 5'h00, 1, 9'h040, 9'h000, 9'h000, 5'h08};
    vecs[2] = '{1, 1'b0, 8'h77, 5'h00, 3, 9'h100, 9'h077, 9'h108, 5'h08};
    vecs[3] = '{0, 1'b1, 8'h00, 5'h00, 1, 9'h100, 9'h000, 9'h000, 5'h00};
    vecs[4] = '{1, 1'b0, 8'h33, 5'h00, 1, 9'h033, 9'h000, 9'h000, 5'h00};
    vecs[5] = '{1, 1'b0, 8'hAA, 5'h05, 3, 9'h105, 9'h0AA, 9'h100, 5'h00};

    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;
    @(negedge clk_sys);
    chk("rst_cs_n", saa_cs_n, 1'b1);
    chk("rst_wr_n", saa_wr_n, 1'b1);
    chk("rst_a0", saa_a0, 1'b0);
    chk("rst_din", saa_din, 8'h00);
    chk("rst_shadow", shadow_addr, 5'h00);
    chk("rst_ovf", cpu_ovf, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_seq_ready", seq_ready, 1'b1);

    for (int k = 0; k < 6; k++) begin
      if (vecs[k].is_seq) seq_push(vecs[k].r, vecs[k].d);
      else cpu_write(vecs[k].a0, vecs[k].d);
      wait_idle($sformatf("vec%0d", k));
      check_beats($sformatf("vec%0d", k), vecs[k].n, vecs[k].e0, vecs[k].e1, vecs[k].e2, 9'h000);
      chk($sformatf("vec%0d_shadow", k), shadow_addr, vecs[k].shadow);
      chk($sformatf("vec%0d_latch", k), latch, vecs[k].shadow);
    end

    // envelope address blocks the sequencer until the CPU moves away
    cpu_write(1'b1, 8'h18);
    wait_idle("env");
    check_beats("env_cpu", 1, 9'h118, 9'h000, 9'h000, 9'h000);
    seq_push(5'h10, 8'h11);
    repeat (20) @(negedge clk_sys);
    chk("env_blocked_beats", beats.size(), 0);
    chk("env_blocked_ready", seq_ready, 1'b1);
    chk("env_blocked_busy", busy, 1'b1);
    cpu_write(1'b1, 8'h1C);
    wait_idle("env_release");
    check_beats("env_release", 4, 9'h11C, 9'h110, 9'h011, 9'h11C);
    chk("env_release_shadow", shadow_addr, 5'h1C);
    chk("env_release_latch", latch, 5'h1C);

    // CPU strobes during an atomic sequence: first waits, second dropped
    chk("ovf_before", cpu_ovf, 1'b0);
    seq_push(5'h03, 8'h55);
    wait_low("atomic");
    cpu_wr = 1'b1; cpu_a0 = 1'b0; cpu_din = 8'h99;
    @(negedge clk_sys);
    cpu_din = 8'hEE;
    @(negedge clk_sys);
    cpu_wr = 1'b0;
    chk("ovf_after", cpu_ovf, 1'b1);
    wait_idle("atomic");
    check_beats("atomic", 4, 9'h103, 9'h055, 9'h11C, 9'h099);
    chk("atomic_latch", latch, 5'h1C);

    // fill FIFO with draining blocked, then reset mid-beat
    cpu_write(1'b1, 8'h19);
    wait_idle("fill");
    beats.delete();
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      seq_valid = 1'b1; seq_reg = 5'(i); seq_data = 8'(i);
      if (seq_ready) accepted++;
    end
    @(negedge clk_sys);
    seq_valid = 1'b0;
    chk("fill_accepted", accepted, 4);
    chk("fill_ready", seq_ready, 1'b0);
    chk("fill_no_beats", beats.size(), 0);
    cpu_write(1'b0, 8'h01);
    wait_low("abort");
    rst_n = 1'b0;
    @(posedge clk_sys);
    #1;
    chk("abort_wr_n", saa_wr_n, 1'b1);
    chk("abort_cs_n", saa_cs_n, 1'b1);
    @(negedge clk_sys);
    rst_n = 1'b1;
    @(negedge clk_sys);
    chk("abort_ready", seq_ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_shadow", shadow_addr, 5'h00);
    chk("abort_ovf", cpu_ovf, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/saa1099_wr_sched.md
Name: saa1099_wr_sched

Overview:
- Write scheduler in front of the saa1099 sound chip's bus port (cs_n/a0/wr_n/din).
- Shares the port between two requesters:
  - CPU I/O writes: raw address or data strobes, high priority.
  - A sequencer requester: register/data pairs through a small FIFO, used by the music player and the config loader.
- Turns every write into a clean wr_n low pulse followed by a gap.
- Keeps the chip's internal address latch coherent with what the CPU last wrote.

Parameters:
- FIFO_DEPTH, 4: sequencer FIFO entries; power of two, at least 2.
- WR_LOW, 2: clk_sys cycles wr_n is held low per beat; at least 1.
- WR_GAP, 2: clk_sys cycles wr_n is held high after each beat; at least 1, so the chip sees a high-to-low edge.

Ports:
- clk_sys, in, 1: system clock.
- rst_n, in, 1: reset, synchronous, active-low.
- cpu_wr, in, 1: one-cycle CPU write strobe.
- cpu_a0, in, 1: 1 = address write, 0 = data write.
- cpu_din, in, 8: CPU write value.
- cpu_ovf, out, 1: sticky; set when a CPU strobe is dropped; cleared only by reset.
- seq_valid, in, 1: sequencer entry offered.
- seq_ready, out, 1: FIFO not full.
- seq_reg, in, 5: target register index.
- seq_data, in, 8: data for that register.
- saa_cs_n, out, 1: chip select to saa1099.
- saa_a0, out, 1: address/data select to saa1099.
- saa_wr_n, out, 1: write strobe to saa1099.
- saa_din, out, 8: data bus to saa1099.
- shadow_addr, out, 5: last address the CPU wrote.
- busy, out, 1: engine not IDLE, or CPU buffer or FIFO non-empty.

Behaviour:
- Reset: outputs, state and storage.
  - saa_cs_n=1, saa_wr_n=1, saa_a0=0, saa_din=0.
  - shadow_addr=0, matching the chip's address-latch reset value. cpu_ovf=0.
  - FIFO empty, CPU buffer empty, FSM in IDLE.
  - Reset mid-beat aborts immediately; wr_n returns high on the next cycle.
- Beat timing.
  - A beat is WR_LOW cycles with saa_cs_n=saa_wr_n=0, then WR_GAP cycles with both high.
  - saa_a0 and saa_din are set on the first low cycle and held through the gap.
- CPU buffer.
  - One entry holding {a0, din}.
  - A cpu_wr strobe loads the buffer whenever it is empty, even mid-beat.
  - A strobe while the buffer is full is dropped and sets cpu_ovf.
  - A CPU address write (a0=1) updates shadow_addr to din[4:0] when its beat starts.
- Sequencer FIFO.
  - An entry is pushed on seq_valid & seq_ready.
  - Push and pop in the same cycle are both allowed.
- FSM states:
  - IDLE:
    - CPU buffer non-empty -> CPU_BEAT.
    - Otherwise, FIFO non-empty and shadow_addr not in {0x18, 0x19} -> SEQ_ADDR. This block exists because restoring 0x18/0x19 would generate a spurious envelope external clock.
    - Otherwise stay in IDLE.
  - CPU_BEAT: one beat with a0=cpu_a0 and din=cpu_din; buffer freed at beat end -> IDLE.
  - SEQ_ADDR: pop the FIFO head.
    - If seq_reg == shadow_addr, skip the beat -> SEQ_DATA.
    - Otherwise one beat with a0=1, din={3'b0, seq_reg} -> SEQ_DATA.
  - SEQ_DATA: one beat with a0=0, din=seq_data.
    - Address was changed -> RESTORE.
    - Address beat was skipped -> IDLE.
  - RESTORE: one beat with a0=1, din={3'b0, shadow_addr} -> IDLE.
- Atomicity.
  - SEQ_ADDR through RESTORE is uninterruptible.
  - CPU strobes arriving during it wait in the buffer, one entry only.
- Priority: the CPU wins every IDLE decision, so the FIFO may starve under continuous CPU traffic (accepted).
- Arithmetic.
  - Beat counter width is clog2(max(WR_LOW, WR_GAP)) + 1.
  - FIFO pointers wrap modulo FIFO_DEPTH, with an extra bit for full/empty.

Decomposition:
- Package saa1099_pkg holds:
  - typedef state_t {IDLE, CPU_BEAT, SEQ_ADDR, SEQ_DATA, RESTORE}.
  - typedef seq_entry_t {reg[4:0], data[7:0]}.
  - Constants ENV_ADDR0=5'h18, ENV_ADDR1=5'h19.
- One sub-module: saa1099_seq_fifo (synchronous FIFO of seq_entry_t).

Test Plan:
- Reset, then CPU address 0x08 followed by data 0x40: two beats, each 2 cycles low and 2 cycles gap, with a0=1/din=0x08 then a0=0/din=0x40; shadow_addr=0x08.
- With shadow_addr=0x08, push seq (0x00, 0x77): beats (1, 0x00), (0, 0x77), then restore (1, 0x08); the chip model's address latch ends at 0x08.
- With shadow_addr=0x00, push seq (0x00, 0x33): address beat skipped, only (0, 0x33), no restore.
- With CPU address 0x18 written, push seq (0x10, 0x11): no beats while shadow=0x18 and seq_ready stays asserted; after CPU address 0x1C, the sequence runs.
- During a seq transaction, issue 2 CPU strobes: the first executes after RESTORE, the second is dropped and cpu_ovf=1.
- Push 5 entries with FIFO_DEPTH=4 and no draining possible: seq_ready deasserts after 4; assert rst_n=0 during a low phase, then saa_wr_n=1 the next cycle and the FIFO is empty.
